// File: rtl/y86_defs.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// data-memory responder state encoding.
package y86_defs;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // Every data access moves one quadword.
    localparam int ACC_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Byte-organised data storage: combinational little-endian quadword read,
// synchronous quadword write with enable; no reset, no backpressure.
module dmem_array #(
    parameter int N     = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  rdata
);

    logic [7:0] mem [DEPTH];

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N / 8; i++) begin
            rdata[8*i +: 8] = mem[addr + AW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < N / 8; i++) begin
                mem[addr + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Y86-64 data-memory responder: one request in flight, response pulse LAT cycles
// after acceptance; req_ready drops while busy, responses cannot be backpressured.
module dmem_responder
    import y86_defs::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_error,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    dmem_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          access;

    logic          cap_write;
    logic [N-1:0]  cap_addr;
    logic [N-1:0]  cap_wdata;

    logic          in_range;
    logic          mem_we;
    logic [N-1:0]  mem_rdata;

    // Full-width compare so wrapped or huge addresses never alias into the array.
    assign in_range  = (cap_addr <= N'(DEPTH - ACC_BYTES));
    assign mem_we    = access && cap_write && in_range && !rst;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(LAT - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= access;
            if (access) begin
                rsp_error <= !in_range;
                rsp_rdata <= (in_range && !cap_write) ? mem_rdata : '0;
            end
        end
    end

    // Request fields are frozen at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    dmem_array #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .addr  (cap_addr[AW-1:0]),
        .we    (mem_we),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LAT=2 instance for data/range/busy/reset
// scenarios and a LAT=1 instance for latency and throughput.
module tb_dmem_responder;

    typedef struct packed {
        logic [63:0] rd;
        logic        er;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;

    logic        req_valid1 = 1'b0;
    logic        req_ready1;
    logic [63:0] req_addr1 = '0;
    logic        rsp_valid1;
    logic [63:0] rsp_rdata1;
    logic        rsp_error1;
    logic        busy1;

    int checks   = 0;
    int failures = 0;

    exp_t       sb [$];
    logic [7:0] mm [1024];

    always #5 clk = ~clk;

    dmem_responder #(.N(64), .DEPTH(1024), .LAT(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .busy      (busy)
    );

    dmem_responder #(.N(64), .DEPTH(1024), .LAT(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_write (1'b0),
        .req_addr  (req_addr1),
        .req_wdata (64'h0),
        .rsp_valid (rsp_valid1),
        .rsp_rdata (rsp_rdata1),
        .rsp_error (rsp_error1),
        .busy      (busy1)
    );

    // Reference memory: computes the expected response and applies stores.
    function automatic exp_t model(input logic w, input logic [63:0] a, input logic [63:0] d);
        exp_t e;
        e.rd = '0;
        e.er = 1'b0;
        if (a > 64'd1016) begin
            e.er = 1'b1;
        end else if (w) begin
            for (int i = 0; i < 8; i++) mm[a[9:0] + 10'(i)] = d[8*i +: 8];
        end else begin
            for (int i = 0; i < 8; i++) e.rd[8*i +: 8] = mm[a[9:0] + 10'(i)];
        end
        return e;
    endfunction

    // Issues one request on the LAT=2 instance from a negedge; returns observed
    // latency (edges after acceptance), response fields and rsp_valid one cycle later.
    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          output int lat, output logic [63:0] rd, output logic er,
                          output logic vld_after);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = ~a;
        req_wdata = ~d;
        req_write = ~w;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            if (rsp_valid) begin
                lat = i;
                rd  = rsp_rdata;
                er  = rsp_error;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        vld_after = rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 5;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (rsp_rdata !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", rsp_error); end
    endtask

    task automatic test_store_load();
        int lat; logic [63:0] rd; logic er; logic va; exp_t e;
        logic [63:0] spec_ld [3];
        logic [63:0] addrs [4];
        logic        wr [4];
        logic [63:0] wd [4];
        addrs = '{64'h10, 64'h18, 64'h10, 64'h11};
        wr    = '{1'b1, 1'b1, 1'b0, 1'b0};
        wd    = '{64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0};
        spec_ld = '{64'h0, 64'h0123456789ABCDEF, 64'h000123456789ABCD};
        for (int k = 0; k < 4; k++) begin
            sb.push_back(model(wr[k], addrs[k], wd[k]));
            do_req(wr[k], addrs[k], wd[k], lat, rd, er, va);
            e = sb.pop_front();
            checks += 4;
            if (lat != 2) begin failures++; $display("FAIL sl_latency[%0d] got=%0d exp=2", k, lat); end
            if (rd !== e.rd) begin failures++; $display("FAIL sl_rdata[%0d] got=%h exp=%h", k, rd, e.rd); end
            if (er !== e.er) begin failures++; $display("FAIL sl_error[%0d] got=%b exp=%b", k, er, e.er); end
            if (va !== 1'b0) begin failures++; $display("FAIL sl_pulse_width[%0d] got=%b exp=0", k, va); end
            if (k >= 2) begin
                checks += 2;
                if (rd !== spec_ld[k-1]) begin failures++; $display("FAIL sl_const[%0d] got=%h exp=%h", k, rd, spec_ld[k-1]); end
                if (rsp_rdata !== spec_ld[k-1]) begin failures++; $display("FAIL sl_hold[%0d] got=%h exp=%h", k, rsp_rdata, spec_ld[k-1]); end
            end
        end
    endtask

    task automatic test_range();
        int lat; logic [63:0] rd; logic er; logic va; exp_t e;
        logic [63:0] addrs [5];
        logic        wr [5];
        addrs = '{64'h3F8, 64'h3F8, 64'h3F9, 64'hFFFF_FFFF_FFFF_FFF8, 64'h3F8};
        wr    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            sb.push_back(model(wr[k], addrs[k], 64'hCAFE_F00D_DEAD_BEEF ^ 64'(k)));
            do_req(wr[k], addrs[k], 64'hCAFE_F00D_DEAD_BEEF ^ 64'(k), lat, rd, er, va);
            e = sb.pop_front();
            checks += 3;
            if (lat != 2) begin failures++; $display("FAIL rng_latency[%0d] got=%0d exp=2", k, lat); end
            if (rd !== e.rd) begin failures++; $display("FAIL rng_rdata[%0d] got=%h exp=%h", k, rd, e.rd); end
            if (er !== e.er) begin failures++; $display("FAIL rng_error[%0d] got=%b exp=%b", k, er, e.er); end
        end
        checks++;
        if (rd !== 64'hCAFE_F00D_DEAD_BEEF) begin failures++; $display("FAIL rng_unchanged got=%h exp=cafef00ddeadbeef", rd); end
    endtask

    task automatic test_busy_hold();
        int acc [2]; int n_acc = 0; int n_rsp = 0; exp_t e;
        acc = '{-1, -1};
        req_write = 1'b0;
        for (int j = 0; j < 16; j++) begin
            req_addr  = (j == 0) ? 64'h10 : 64'h400 + 64'(j);
            req_valid = (n_acc < 2);
            if (j == 1) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b exp=1", busy); end
            end
            if (rsp_valid) begin
                n_rsp++;
                checks += 2;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL hold_unexpected_rsp got=1 exp=0");
                end else begin
                    e = sb.pop_front();
                    if (rsp_rdata !== e.rd) begin failures++; $display("FAIL hold_rdata got=%h exp=%h", rsp_rdata, e.rd); end
                    if (rsp_error !== e.er) begin failures++; $display("FAIL hold_error got=%b exp=%b", rsp_error, e.er); end
                end
            end
            if (req_valid && req_ready) begin
                acc[n_acc] = j;
                n_acc++;
                sb.push_back(model(1'b0, req_addr, 64'h0));
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks += 3;
        if (acc[0] != 0) begin failures++; $display("FAIL hold_first_accept got=%0d exp=0", acc[0]); end
        if (acc[1] - acc[0] != 4) begin failures++; $display("FAIL hold_accept_gap got=%0d exp=4", acc[1] - acc[0]); end
        if (n_rsp != 2) begin failures++; $display("FAIL hold_rsp_count got=%0d exp=2", n_rsp); end
        sb.delete();
    endtask

    task automatic test_reset_mid_store();
        int lat; logic [63:0] rd; logic er; logic va; int pulses = 0;
        sb.push_back(model(1'b1, 64'h20, 64'h1111_1111_1111_1111));
        do_req(1'b1, 64'h20, 64'h1111_1111_1111_1111, lat, rd, er, va);
        void'(sb.pop_front());
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 1) rst = 1'b0;
            if (rsp_valid) pulses++;
        end
        checks += 2;
        if (pulses != 0) begin failures++; $display("FAIL rms_no_rsp got=%0d exp=0", pulses); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rms_idle got=%b exp=0", busy); end
        sb.push_back(model(1'b0, 64'h20, 64'h0));
        do_req(1'b0, 64'h20, 64'h0, lat, rd, er, va);
        checks += 2;
        if (rd !== sb[0].rd) begin failures++; $display("FAIL rms_rdata got=%h exp=%h", rd, sb[0].rd); end
        if (rd !== 64'h1111_1111_1111_1111) begin failures++; $display("FAIL rms_const got=%h exp=1111111111111111", rd); end
        void'(sb.pop_front());
    endtask

    task automatic test_lat1();
        int acc [3]; int rsp [3]; int n_acc = 0; int n_rsp = 0; exp_t e;
        for (int j = 0; j < 14; j++) begin
            req_addr1  = 64'h400 + 64'(j);
            req_valid1 = (n_acc < 3);
            if (rsp_valid1) begin
                checks += 2;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL lat1_unexpected_rsp got=1 exp=0");
                end else begin
                    e = sb.pop_front();
                    if (rsp_error1 !== e.er) begin failures++; $display("FAIL lat1_error got=%b exp=%b", rsp_error1, e.er); end
                    if (rsp_rdata1 !== e.rd) begin failures++; $display("FAIL lat1_rdata got=%h exp=%h", rsp_rdata1, e.rd); end
                end
                if (n_rsp < 3) rsp[n_rsp] = j;
                n_rsp++;
            end
            if (req_valid1 && req_ready1) begin
                acc[n_acc] = j;
                n_acc++;
                sb.push_back(model(1'b0, req_addr1, 64'h0));
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid1 = 1'b0;
        checks++;
        if (n_acc != 3 || n_rsp != 3) begin
            failures++; $display("FAIL lat1_counts got=%0d/%0d exp=3/3", n_acc, n_rsp);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rsp[k] - acc[k] != 2) begin failures++; $display("FAIL lat1_latency[%0d] got=%0d exp=2", k, rsp[k] - acc[k]); end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (acc[k] - acc[k-1] != 3) begin failures++; $display("FAIL lat1_gap[%0d] got=%0d exp=3", k, acc[k] - acc[k-1]); end
            end
        end
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
        test_reset();
        test_store_load();
        test_range();
        test_busy_hold();
        test_reset_mid_store();
        test_lat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined Y86-64 core. It serves the memory stage's load/store requests (`rmmovq`, `mrmovq`, `pushq`, `popq`, `call`, `ret`) over a valid/ready request channel and a one-cycle response pulse. It has fixed, parameterised latency, byte-addressed little-endian 8-byte accesses, and out-of-range detection that feeds the SADR status. It sits at the far end of the M-stage pipeline register: the memory stage issues requests, and this block answers them.

## Interface
Parameters:
- `N`, 64: data and address width.
- `DEPTH`, 1024: memory size in bytes; must be at least 8.
- `LAT`, 2: response latency in cycles, counted from request acceptance; must be at least 1.

Ports:
- `clk`, input, 1: sole clock; everything is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: block can accept a request.
- `req_write`, input, 1: 1 = store, 0 = load.
- `req_addr`, input, N: byte address (M-stage valE or valA).
- `req_wdata`, input, N: store data.
- `rsp_valid`, output, 1: response pulse, exactly one cycle wide.
- `rsp_rdata`, output, N: load data; 0 for stores and errors.
- `rsp_error`, output, 1: address out of range; the memory stage maps this to SADR.
- `busy`, output, 1: a request is in flight; used by pipeline control to stall.

## Operation
FSM states: IDLE, WAIT, RESP.

- **IDLE**
  - `req_ready`=1.
  - On an edge with `req_valid`: capture `req_write`, `req_addr` and `req_wdata`, load `cnt`=LAT-1, go to WAIT.
- **WAIT**
  - `req_ready`=0; `req_valid` is ignored.
  - While `cnt`≠0: decrement `cnt` each edge.
  - At the edge where `cnt`=0, perform the access and go to RESP.
- **The access**
  - Range check on the full N-bit unsigned captured address: in range iff `addr` ≤ DEPTH-8.
  - Out of range: `rsp_error`=1, `rsp_rdata`=0, memory unchanged.
  - In-range load: `rsp_rdata` = {mem[a+7], …, mem[a]} (little-endian), `rsp_error`=0.
  - In-range store: mem[a+i] ← wdata[8i+7:8i] for i = 0..7, `rsp_rdata`=0, `rsp_error`=0.
  - Unaligned addresses are legal.
- **RESP**
  - `rsp_valid`=1. There is no backpressure; the consumer always takes the response.
  - Next edge: `rsp_valid`←0 and return to IDLE.
  - `rsp_rdata` and `rsp_error` hold their values until the next response.
- **busy** = (state ≠ IDLE).
- **Capture**: inputs are sampled only on the acceptance edge. Later input changes do not affect the in-flight access.
- **Reset** (takes priority over all other behaviour):
  - state←IDLE, `cnt`←0, `rsp_valid`←0, `rsp_rdata`←0, `rsp_error`←0.
  - Memory contents are not reset.
  - A store in flight when reset is asserted before its access edge is dropped; memory is unchanged.

## Timing
- Request accepted at edge E0.
- `rsp_valid` is high in the cycle after edge E0+LAT, i.e. LAT cycles after acceptance.
- `req_ready` returns to 1 in the cycle after edge E0+LAT+1.
- The next acceptance is possible at the earliest at edge E0+LAT+2, so throughput is one request per LAT+2 cycles.
- Store-to-load ordering: a load accepted after a store's response sees the stored bytes.
- Reset values of every output:
  - `req_ready`=1 (state IDLE).
  - `rsp_valid`=0.
  - `rsp_rdata`=0.
  - `rsp_error`=0.
  - `busy`=0.
- With LAT=1, WAIT lasts one cycle (`cnt` loaded as 0).

## Structure
- Shared package/include `y86_defs`:
  - icode constants.
  - STAT codes (SAOK, SADR, SINS, SHLT).
  - The FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
- Sub-module `dmem_array`:
  - DEPTH×8 byte storage.
  - One 8-byte little-endian read port (combinational on address).
  - One synchronous 8-byte write port with enable.
  - No reset.
- `dmem_responder` contains the FSM, latency counter, capture registers, range check and response registers.

## Test plan
- **Reset release:** after `rst` is deasserted, `req_ready`=1, `rsp_valid`=0, `busy`=0, `rsp_rdata`=0, `rsp_error`=0.
- **Store then load (LAT=2):**
  - Store 0x0123456789ABCDEF to address 0x10.
  - `rsp_valid` pulses exactly 2 cycles after acceptance, with `rsp_rdata`=0 and `rsp_error`=0.
  - A load from 0x10 then returns 0x0123456789ABCDEF.
  - A load from 0x11 returns 0x000123456789ABCD in the high bytes, given a zero-initialised byte at 0x18 (write 0 there first).
- **Range boundary (DEPTH=1024):**
  - Load from 0x3F8 gives `rsp_error`=0.
  - Load from 0x3F9 gives `rsp_error`=1 with `rsp_rdata`=0.
  - Store to 0xFFFFFFFFFFFFFFF8 gives `rsp_error`=1, and a subsequent load from 0x3F8 is unchanged.
- **Busy hold:** hold `req_valid` high with changing `addr` while `busy`=1. Only the first request is served, and the second is accepted exactly at edge E0+LAT+2.
- **Reset mid-store:**
  - Store 0xAA…AA to 0x20, then assert `rst` one cycle after acceptance.
  - No `rsp_valid` appears.
  - A later load from 0x20 returns the previously written 0x1111111111111111.
- **LAT=1 build:** `rsp_valid` appears 1 cycle after acceptance, and back-to-back requests are accepted every 3 cycles.
